enc: RTL and testbench

//  - Registered 4-to-2 binary encoder. Converts a one-hot request vector into its bit index.
//  - Resolves multi-hot inputs by highest-index priority.
//  - Flags the all-zero input with a valid bit.
//  - Sits between request/select logic and index-consuming datapath muxes.

---
 rtl/enc_pkg.sv | 10 +
 rtl/enc_prio_core.sv | 35 +++
 rtl/enc.sv | 58 +++++
 tb/tb_enc.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared sizing and payload types for the enc priority encoder.
package enc_pkg;

  localparam int unsigned ENC_N = 4;
  localparam int unsigned ENC_W = $clog2(ENC_N);

  typedef logic [ENC_N-1:0] enc_req_t;
  typedef logic [ENC_W-1:0] enc_idx_t;

endpackage : enc_pkg

// File: rtl/enc_prio_core.sv
// Combinational highest-index priority core for the enc encoder.
// Macro ENC_ONEHOT_CHK_EN adds the multi-hot detect output.
module enc_prio_core
  import enc_pkg::*;
#(
  parameter int unsigned N = ENC_N
) (
  input  logic [N-1:0]         y,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
`ifdef ENC_ONEHOT_CHK_EN
, output logic                 multi
`endif
);

  localparam int unsigned W = $clog2(N);

  // Ascending scan so the highest set bit wins.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (y[i]) begin
        idx = W'(i);
      end
    end
  end

  assign any = |y;

`ifdef ENC_ONEHOT_CHK_EN
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(y & (y - N'(1)));
`endif

endmodule : enc_prio_core

// File: rtl/enc.sv
// Registered N-to-log2(N) priority encoder with a valid flag; one cycle latency.
// Macro ENC_ONEHOT_CHK_EN adds the registered multi-hot error output err.
module enc
  import enc_pkg::*;
#(
  parameter int unsigned N = ENC_N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         y,
  output logic [$clog2(N)-1:0] a,
  output logic                 vld
`ifdef ENC_ONEHOT_CHK_EN
, output logic                 err
`endif
);

  localparam int unsigned W = $clog2(N);

  logic [W-1:0] idx_c;
  logic         any_c;
`ifdef ENC_ONEHOT_CHK_EN
  logic         multi_c;
`endif

  enc_prio_core #(
    .N(N)
  ) u_core (
    .y  (y),
    .idx(idx_c),
    .any(any_c)
`ifdef ENC_ONEHOT_CHK_EN
  , .multi(multi_c)
`endif
  );

  // Output register bank; the zero-input case already yields idx 0 from the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a   <= '0;
      vld <= 1'b0;
    end else begin
      a   <= idx_c;
      vld <= any_c;
    end
  end

`ifdef ENC_ONEHOT_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= multi_c;
    end
  end
`endif

endmodule : enc

// File: tb/tb_enc.sv
// Self-checking bench for enc: directed scenarios plus randomized traffic vs. a reference model.
module tb_enc;
  import enc_pkg::*;

  logic           clk;
  logic           rst;
  logic [3:0]     y;
  logic [1:0]     a;
  logic           vld;
  logic           err_s;

  int checks;
  int errors;

`ifdef ENC_ONEHOT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  enc dut (
    .clk(clk),
    .rst(rst),
    .y  (y),
    .a  (a),
    .vld(vld)
`ifdef ENC_ONEHOT_CHK_EN
  , .err(err_s)
`endif
  );

`ifndef ENC_ONEHOT_CHK_EN
  assign err_s = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {a, vld, err}: a = floor(log2(v)) for v>0 else 0; err = more than one bit set.
  function automatic logic [3:0] model(input logic [3:0] v);
    int t;
    int k;
    int cnt;
    logic e;
    t = int'(v);
    k = 0;
    while (t > 1) begin
      t = t / 2;
      k++;
    end
    cnt = 0;
    t = int'(v);
    while (t > 0) begin
      cnt += t % 2;
      t = t / 2;
    end
    e = CHK && (cnt > 1);
    return {2'(k), (v != 4'd0), e};
  endfunction

  task automatic test_reset();
    logic [3:0] obs;
    rst = 1'b1;
    y   = 4'b1000;
    #2;
    obs = {a, vld, err_s};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: got %b want 0000", obs);
    end
    @(posedge clk);
    #1;
    obs = {a, vld, err_s};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_held: got %b want 0000", obs);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    obs = {a, vld, err_s};
    checks++;
    if (obs !== model(4'b1000)) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", obs, model(4'b1000));
    end
  endtask

  task automatic test_onehot_sweep();
    logic [3:0] obs;
    logic [3:0] v;
    logic [3:0] want;
    for (int j = 0; j < 4; j++) begin
      v = 4'(1 << j);
      y = v;
      @(posedge clk);
      #1;
      obs  = {a, vld, err_s};
      want = {2'(j), 1'b1, 1'b0};
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL onehot_%0d: got %b want %b", j, obs, want);
      end
    end
  endtask

  task automatic test_zero();
    logic [3:0] obs;
    y = 4'b0000;
    @(posedge clk);
    #1;
    obs = {a, vld, err_s};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL zero_input: got %b want 0000", obs);
    end
  endtask

  task automatic test_priority();
    logic [3:0] obs;
    logic [3:0] pats [3];
    logic [3:0] want [3];
    pats[0] = 4'b0110; want[0] = {2'd2, 1'b1, CHK};
    pats[1] = 4'b1111; want[1] = {2'd3, 1'b1, CHK};
    pats[2] = 4'b0011; want[2] = {2'd1, 1'b1, CHK};
    for (int i = 0; i < 3; i++) begin
      y = pats[i];
      @(posedge clk);
      #1;
      obs = {a, vld, err_s};
      checks++;
      if (obs !== want[i]) begin
        errors++;
        $display("FAIL priority_%b: got %b want %b", pats[i], obs, want[i]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [3:0] obs;
    y = 4'b0100;
    @(posedge clk);
    #1;
    y = 4'b1000;
    #2;
    rst = 1'b1;
    #1;
    obs = {a, vld, err_s};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_clear: got %b want 0000", obs);
    end
    y = 4'b0010;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    obs = {a, vld, err_s};
    checks++;
    if (obs !== model(4'b0010)) begin
      errors++;
      $display("FAIL midreset_first: got %b want %b", obs, model(4'b0010));
    end
  endtask

  task automatic test_latency();
    logic [3:0] obs;
    y = 4'b0001;
    @(posedge clk);
    #1;
    y = 4'b1100;
    #3;
    obs = {a, vld, err_s};
    checks++;
    if (obs !== model(4'b0001)) begin
      errors++;
      $display("FAIL latency_hold: got %b want %b", obs, model(4'b0001));
    end
    @(posedge clk);
    #1;
    obs = {a, vld, err_s};
    checks++;
    if (obs !== model(4'b1100)) begin
      errors++;
      $display("FAIL latency_update: got %b want %b", obs, model(4'b1100));
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs;
    logic [3:0] v;
    for (int i = 0; i < 200; i++) begin
      v = 4'($urandom_range(0, 15));
      y = v;
      @(posedge clk);
      #1;
      obs = {a, vld, err_s};
      checks++;
      if (obs !== model(v)) begin
        errors++;
        $display("FAIL random_%0d y=%b: got %b want %b", i, v, obs, model(v));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_onehot_sweep();
    test_zero();
    test_priority();
    test_midstream_reset();
    test_latency();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_enc
